board_monitor: RTL

//   Parametrised board-level debug monitor that replaces the fixed "LED = pc[15:0]" tie-off.

---
 rtl/board_monitor.sv | 105 ++++++++++
 1 files changed

// File: rtl/board_monitor.sv
// board_monitor: probe-channel LED debug monitor with debounced channel/mode buttons and heartbeat
module board_monitor_debounce #(
   parameter int CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int CW = $clog2(CYCLES);
   logic s1, s2, level, armed;
   logic [CW-1:0] cnt;
   logic done;
   assign done = cnt == CW'(CYCLES - 1);
   assign press = armed && s2 && !level && done;
   // synchronise, then require a run of equal samples; stay unarmed until a stable release is seen after reset
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         level <= 1'b0;
         armed <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         if (!armed) begin
            armed <= done && !(s1 | s2);
            cnt <= (s1 | s2 | done) ? '0 : cnt + 1'b1;
         end else if (s2 == level) cnt <= '0;
         else if (done) begin
            level <= s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
endmodule

module board_monitor #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int LED_W = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HB_DIV_W = 24,
   localparam int NSL = DATA_W / LED_W,
   localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
   localparam int SL_W = ($clog2(NSL) > 1) ? $clog2(NSL) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] probe_data,
   input  logic [NUM_CH-1:0]        probe_valid,
   input  logic                     btn_sel,
   input  logic                     btn_mode,
   input  logic [SL_W-1:0]          slice_sel,
   output logic [LED_W-1:0]         led,
   output logic [CH_W-1:0]          cur_ch,
   output logic [1:0]               cur_mode,
   output logic                     hb
);
   logic sel_p, mode_p, cur_valid;
   logic [DATA_W-1:0] live, cap, evcnt, v;
   logic [HB_DIV_W-1:0] div;
   logic [LED_W-1:0] walk, slice_v;
   board_monitor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel (.clk(clk), .rst(rst), .btn(btn_sel), .press(sel_p));
   board_monitor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(mode_p));
   assign hb = div[HB_DIV_W-1];
   // select the display source and cut out the requested LED slice
   always_comb begin
      live = probe_data[int'(cur_ch)*DATA_W +: DATA_W];
      cur_valid = probe_valid[cur_ch];
      v = (cur_mode == 2'd1) ? cap : (cur_mode == 2'd2) ? evcnt : live;
      slice_v = (int'(slice_sel) < NSL) ? v[int'(slice_sel)*LED_W +: LED_W] : '0;
   end
   // free-running heartbeat divider and walking-one pattern advanced on each divider wrap
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div <= '0;
         walk <= LED_W'(1);
      end else begin
         div <= div + 1'b1;
         if (&div) walk <= {walk[LED_W-2:0], walk[LED_W-1]};
      end
   // channel/mode selection and tracking of the selected channel; a channel change discards any coincident sample
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cur_ch <= '0;
         cur_mode <= 2'd0;
         cap <= '0;
         evcnt <= '0;
      end else begin
         if (mode_p) cur_mode <= cur_mode + 2'd1;
         if (sel_p) begin
            cur_ch <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
            cap <= '0;
            evcnt <= '0;
         end else if (cur_valid) begin
            cap <= live;
            evcnt <= evcnt + 1'b1;
         end
      end
   // registered LED drive
   always_ff @(posedge clk or posedge rst)
      if (rst) led <= '0;
      else led <= (cur_mode == 2'd3) ? walk : slice_v;
endmodule
